// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Clocked, self-checking stimulus/response stage around a combinational function
//   F(A,B,C,D). It drives every input vector in ascending order with A as the MSB, and holds
//   each vector HOLD cycles. It samples F once the vector has settled and compares the sample
//   against the expected truth table EXPECT. At the end it reports the captured table, the
//   mismatch count and the lowest failing vector.
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        sweep request, accepted in idle or done
//   f_in         output F of the function under test
//   abcd         registered function inputs {A,B,C,D}
//   busy         sweep in progress
//   done         sweep complete, sticky until the next accepted start or reset
//   captured     sampled F per vector, bit i = vector i
//   mismatch_cnt number of vectors whose sample differs from EXPECT
//   first_err    index of the lowest mismatching vector
//   err_valid    first_err holds a real mismatch
module truth_table_sweeper #(
   parameter int unsigned           N_IN   = 4,
   parameter int unsigned           HOLD   = 4,
   parameter int unsigned           SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]  EXPECT = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   f_in,
   output logic [N_IN-1:0]        abcd,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   captured,
   output logic [N_IN:0]          mismatch_cnt,
   output logic [N_IN-1:0]        first_err,
   output logic                   err_valid
);

   localparam int unsigned     HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
   localparam logic [HW-1:0]   SETTLE_AT = HW'(SETTLE);
   localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t          state;
   logic [N_IN-1:0] vec;
   logic [HW-1:0]   hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= StIdle;
         vec          <= '0;
         hold         <= '0;
         abcd         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         captured     <= '0;
         mismatch_cnt <= '0;
         first_err    <= '0;
         err_valid    <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state        <= StRun;
                  vec          <= '0;
                  hold         <= '0;
                  abcd         <= '0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  captured     <= '0;
                  mismatch_cnt <= '0;
                  first_err    <= '0;
                  err_valid    <= 1'b0;
               end
            end
            StRun: begin
               // start is deliberately ignored here; a running sweep always completes
               hold <= hold + 1'b1;
               // Sample only once abcd has been stable long enough to mask input glitches
               if (hold == SETTLE_AT) begin
                  captured[vec] <= f_in;
                  if (f_in != EXPECT[vec]) begin
                     mismatch_cnt <= mismatch_cnt + 1'b1;
                     if (!err_valid) begin
                        first_err <= vec;
                        err_valid <= 1'b1;
                     end
                  end
               end
               if (hold == HOLD_LAST) begin
                  hold <= '0;
                  if (vec != VEC_LAST) begin
                     vec  <= vec + 1'b1;
                     abcd <= vec + 1'b1;
                  end else begin
                     state <= StDone;
                     vec   <= '0;
                     abcd  <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic f_in;

   logic [3:0]  abcd0, abcd1, abcd2;
   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;
   logic [15:0] cap0, cap1, cap2;
   logic [4:0]  mcnt0, mcnt1, mcnt2;
   logic [3:0]  ferr0, ferr1, ferr2;
   logic        ev0, ev1, ev2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   truth_table_sweeper #(.N_IN(4), .HOLD(4), .SETTLE(2), .EXPECT(16'h0000)) u0 (
      .clk(clk), .rst(rst), .start(start), .f_in(f_in), .abcd(abcd0), .busy(busy0),
      .done(done0), .captured(cap0), .mismatch_cnt(mcnt0), .first_err(ferr0), .err_valid(ev0)
   );
   truth_table_sweeper #(.N_IN(4), .HOLD(4), .SETTLE(2), .EXPECT(16'hF000)) u1 (
      .clk(clk), .rst(rst), .start(start), .f_in(f_in), .abcd(abcd1), .busy(busy1),
      .done(done1), .captured(cap1), .mismatch_cnt(mcnt1), .first_err(ferr1), .err_valid(ev1)
   );
   truth_table_sweeper #(.N_IN(4), .HOLD(4), .SETTLE(2), .EXPECT(16'hF001)) u2 (
      .clk(clk), .rst(rst), .start(start), .f_in(f_in), .abcd(abcd2), .busy(busy2),
      .done(done2), .captured(cap2), .mismatch_cnt(mcnt2), .first_err(ferr2), .err_valid(ev2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Response of the function under test, n cycles after the accepting edge.
   // Mode 3 drives the wrong value during hold 0..1 to emulate settling glitches.
   function automatic logic f_for(input int mode, input int n);
      logic [3:0] v;
      int         ph;
      v  = 4'(n / 4);
      ph = n % 4;
      case (mode)
         0:       return 1'b0;
         1:       return v[3] & v[2];
         2:       return 1'b1;
         default: return (ph < 2) ? ~v[0] : v[0];
      endcase
   endfunction

   task automatic run_sweep(input int mode, input int poke_at, input int abort_at);
      int n;
      bit ab;
      n  = 0;
      ab = 1'b0;
      @(negedge clk);
      start = 1'b1;
      f_in  = f_for(mode, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("e0_busy", busy0, 1);
      check("e0_abcd", abcd0, 0);
      check("e0_done_clr", done0, 0);
      check("e0_cap_clr", cap0, 0);
      check("e0_mcnt_clr", mcnt0, 0);
      check("e0_ev_clr", ev0, 0);
      while (n < 64 && !ab) begin
         f_in = f_for(mode, n);
         if (n == poke_at) begin
            check("poke_abcd", abcd0, 3);
            start = 1'b1;
         end
         if (n == abort_at) begin
            check("pre_abort_abcd", abcd0, 7);
            rst = 1'b1;
            #1;
            check("abort_abcd", abcd0, 0);
            check("abort_busy", busy0, 0);
            check("abort_done", done0, 0);
            check("abort_cap", cap0, 0);
            check("abort_mcnt", mcnt0, 0);
            check("abort_ferr", ferr0, 0);
            check("abort_ev", ev0, 0);
            @(negedge clk);
            rst = 1'b0;
            ab  = 1'b1;
         end else begin
            if (n == 63) begin
               check("pre_end_busy", busy0, 1);
               check("pre_end_done", done0, 0);
               check("pre_end_abcd", abcd0, 15);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
         end
      end
      if (!ab) begin
         check("end_done", done0, 1);
         check("end_busy", busy0, 0);
         check("end_abcd", abcd0, 0);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      f_in  = 1'b0;
      #1;
      check("rst_abcd", abcd0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_ev", ev0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: constant 0
      run_sweep(0, -1, -1);
      check("t1_cap0", cap0, 16'h0000);
      check("t1_mcnt0", mcnt0, 0);
      check("t1_ev0", ev0, 0);
      check("t1_mcnt1", mcnt1, 4);
      check("t1_ferr1", ferr1, 12);
      check("t1_ev1", ev1, 1);

      // 2/3: F = A & B
      run_sweep(1, -1, -1);
      check("t2_cap1", cap1, 16'hF000);
      check("t2_mcnt1", mcnt1, 0);
      check("t2_ev1", ev1, 0);
      check("t3_mcnt2", mcnt2, 1);
      check("t3_ferr2", ferr2, 0);
      check("t3_ev2", ev2, 1);
      check("t2_mcnt0", mcnt0, 4);
      check("t2_ferr0", ferr0, 12);

      // 4: constant 1
      run_sweep(2, -1, -1);
      check("t4_cap0", cap0, 16'hFFFF);
      check("t4_mcnt0", mcnt0, 16);
      check("t4_ferr0", ferr0, 0);
      check("t4_mcnt1", mcnt1, 12);

      // 5: start pulse mid-sweep is ignored
      run_sweep(1, 12, -1);
      check("t5_cap1", cap1, 16'hF000);
      check("t5_mcnt1", mcnt1, 0);

      // 5: reset at vector 7, then a full sweep
      run_sweep(0, -1, 28);
      check("t5_idle_busy", busy0, 0);
      run_sweep(2, -1, -1);
      check("t5r_cap0", cap0, 16'hFFFF);
      check("t5r_mcnt0", mcnt0, 16);

      // 6: glitches before settle, stable value = D
      run_sweep(3, -1, -1);
      check("t6_cap0", cap0, 16'hAAAA);
      check("t6_mcnt0", mcnt0, 8);
      check("t6_ferr0", ferr0, 1);
      check("t6_mcnt1", mcnt1, 8);
      check("t6_ferr1", ferr1, 1);

      // back-to-back start from done clears results (checked at E0 inside run_sweep)
      run_sweep(1, -1, -1);
      check("t6b_cap1", cap1, 16'hF000);
      check("t6b_mcnt1", mcnt1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
